datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles waiting on mem_ready before abort.
REQ-002 Parameter: CNT_W, default 4, width of timeout counter; SHALL satisfy 2**CNT_W > TIMEOUT.
REQ-003 Parameter: HALT_EN, default 1, 1 = opcode 111 halts; 0 = opcode 111 decodes as illegal.
REQ-004 clk  in  1  rising-edge clock, only clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 s  in  1  start; sampled in S_WAIT only.
REQ-007 opcode  in  3  instruction class, stable from S_WAIT exit until return to S_WAIT.
REQ-008 op  in  2  sub-operation, same stability as opcode.
REQ-009 mem_ready  in  1  memory completion strobe, one cycle.
REQ-010 w  out  1  idle flag, 1 only in S_WAIT.
REQ-011 loada, loadb, loadc, loads  out  1 each  datapath register load enables.
REQ-012 write  out  1  register-file write enable.
REQ-013 nsel  out  3  one-hot register select {Rd,Rm,Rn}; 000 when unused.
REQ-014 vsel  out  2  writeback mux: 00 C, 01 PC, 10 IMM, 11 MDATA.
REQ-015 asel  out  1  1 = ALU A operand forced to zero.
REQ-016 bsel  out  1  1 = ALU B operand is sign-extended immediate.
REQ-017 load_addr  out  1  address register load enable.
REQ-018 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-019 halted  out  1  1 in S_HALT.
REQ-020 err  out  1  sticky error flag, cleared only by reset.

Function
REQ-021 Moore FSM; all outputs SHALL be decoded from current state only; default every output 0 in states not listed below.
REQ-022 S_WAIT: w=1; s=1 -> S_DECODE, else stay.
REQ-023 S_DECODE: {110,10} -> S_WIMM; {110,00} -> S_GETB; {101,xx} -> S_GETA; {011,00} or {100,00} -> S_GETA; {111,xx} with HALT_EN=1 -> S_HALT; anything else -> S_WAIT with err set next edge.
REQ-024 S_WIMM: nsel=100, vsel=10, write=1; -> S_WAIT.
REQ-025 S_GETA: nsel=001, loada=1; -> S_GETB for opcode 101, -> S_ADDR for 011/100.
REQ-026 S_GETB: nsel=010, loadb=1; op=01 with opcode 101 -> S_COMP; op=11 with 101 or opcode 110 -> S_ALU with asel=1 in S_ALU; else -> S_ALU.
REQ-027 S_ALU: loadc=1, asel per REQ-026; -> S_WREG.
REQ-028 S_COMP: loads=1; -> S_WAIT; write SHALL remain 0.
REQ-029 S_WREG: nsel=100, vsel=00, write=1; -> S_WAIT.
REQ-030 S_ADDR: bsel=1, loadc=1, load_addr=1; -> S_MRD (011) or S_MWR_GET (100).
REQ-031 S_MWR_GET: nsel=100, loadb=1, asel=1; -> S_MWR.
REQ-032 S_MRD: mem_req=1, mem_we=0; mem_ready=1 -> S_WMEM.
REQ-033 S_MWR: mem_req=1, mem_we=1; mem_ready=1 -> S_WAIT.
REQ-034 S_WMEM: nsel=100, vsel=11, write=1; -> S_WAIT.
REQ-035 Timeout counter cleared on entry to S_MRD/S_MWR, increments each cycle there without mem_ready; reaching TIMEOUT -> S_WAIT next edge, err set, no write issued.
REQ-036 mem_ready on the same edge the counter reaches TIMEOUT: completion SHALL win, err unchanged.
REQ-037 mem_ready outside S_MRD/S_MWR SHALL be ignored.
REQ-038 S_HALT: halted=1; stays until reset; s ignored.
REQ-039 Unused state encodings SHALL return to S_WAIT next edge and set err.

Reset
REQ-040 rst_n=0 SHALL immediately force S_WAIT, counter 0, err 0, regardless of clock.
REQ-041 During reset: w=1, all other outputs 0; reset mid-memory-access SHALL drop mem_req combinationally.
REQ-042 First state change after rst_n rises SHALL occur no earlier than the next rising clk edge.

Verification
REQ-043 MOV imm {110,10}, s pulse -> S_DECODE, S_WIMM (nsel=100, vsel=10, write=1), w=1 on cycle 3.
REQ-044 ADD {101,00} -> loada, loadb, loadc, write with nsel=100, vsel=00 on 4 consecutive cycles after decode; CMP {101,01} -> loads=1, write never 1.
REQ-045 LDR {011,00}, mem_ready at 3rd S_MRD cycle -> mem_req high exactly 3 cycles, then write=1 with vsel=11.
REQ-046 STR {100,00}, mem_ready never -> mem_req high TIMEOUT (15) cycles, return to S_WAIT, err=1, no write.
REQ-047 Illegal {000,00} -> S_WAIT after decode, err=1; then HALT {111,00} -> halted=1 held for 20 cycles with s toggling.
REQ-048 rst_n low in S_MRD -> mem_req=0 before next clk edge, err=0, w=1.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath/memory side.
// The master modport is the sequencer; the slave modport is the datapath it steers.
interface datapath_sequencer_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic       w;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       write;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       asel;
  logic       bsel;
  logic       load_addr;
  logic       mem_req;
  logic       mem_we;
  logic       halted;
  logic       err;

  modport master (
    input  s, opcode, op, mem_ready,
    output w, loada, loadb, loadc, loads, write, nsel, vsel,
           asel, bsel, load_addr, mem_req, mem_we, halted, err
  );

  modport slave (
    output s, opcode, op, mem_ready,
    input  w, loada, loadb, loadc, loads, write, nsel, vsel,
           asel, bsel, load_addr, mem_req, mem_we, halted, err
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Moore control FSM for a small load/store datapath: register moves, ALU ops,
// compares, memory read/write with a ready timeout, and halt.
module datapath_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4,
  parameter bit HALT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  datapath_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_WAIT    = 4'd0,
    S_DECODE  = 4'd1,
    S_WIMM    = 4'd2,
    S_GETA    = 4'd3,
    S_GETB    = 4'd4,
    S_ALU     = 4'd5,
    S_ALU_Z   = 4'd6,
    S_COMP    = 4'd7,
    S_WREG    = 4'd8,
    S_ADDR    = 4'd9,
    S_MWR_GET = 4'd10,
    S_MRD     = 4'd11,
    S_MWR     = 4'd12,
    S_WMEM    = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  // Last cycle index spent waiting; the abort edge follows it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      S_WAIT:   if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == 3'b110 && bus.op == 2'b10)                      state_d = S_WIMM;
        else if (bus.opcode == 3'b110 && bus.op == 2'b00)                 state_d = S_GETB;
        else if (bus.opcode == 3'b101)                                    state_d = S_GETA;
        else if ((bus.opcode == 3'b011 || bus.opcode == 3'b100) && bus.op == 2'b00)
                                                                          state_d = S_GETA;
        else if (bus.opcode == 3'b111 && HALT_EN)                         state_d = S_HALT;
        else begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_WIMM:   state_d = S_WAIT;
      S_GETA:   state_d = (bus.opcode == 3'b101) ? S_GETB : S_ADDR;
      S_GETB: begin
        if (bus.opcode == 3'b101 && bus.op == 2'b01)                      state_d = S_COMP;
        else if ((bus.opcode == 3'b101 && bus.op == 2'b11) || bus.opcode == 3'b110)
                                                                          state_d = S_ALU_Z;
        else                                                              state_d = S_ALU;
      end
      S_ALU, S_ALU_Z: state_d = S_WREG;
      S_COMP, S_WREG, S_WMEM: state_d = S_WAIT;
      S_ADDR:    state_d = (bus.opcode == 3'b011) ? S_MRD : S_MWR_GET;
      S_MWR_GET: state_d = S_MWR;
      S_MRD, S_MWR: begin
        // Completion is checked first so a ready on the final cycle still wins.
        if (bus.mem_ready) begin
          state_d = (state_q == S_MRD) ? S_WMEM : S_WAIT;
        end else if (timeout_hit) begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_WAIT;
        err_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.w         = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.write     = 1'b0;
    bus.nsel      = 3'b000;
    bus.vsel      = 2'b00;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.load_addr = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.halted    = 1'b0;
    bus.err       = err_q;
    case (state_q)
      S_WAIT:    bus.w = 1'b1;
      S_WIMM:    begin bus.nsel = 3'b100; bus.vsel = 2'b10; bus.write = 1'b1; end
      S_GETA:    begin bus.nsel = 3'b001; bus.loada = 1'b1; end
      S_GETB:    begin bus.nsel = 3'b010; bus.loadb = 1'b1; end
      S_ALU:     bus.loadc = 1'b1;
      S_ALU_Z:   begin bus.loadc = 1'b1; bus.asel = 1'b1; end
      S_COMP:    bus.loads = 1'b1;
      S_WREG:    begin bus.nsel = 3'b100; bus.vsel = 2'b00; bus.write = 1'b1; end
      S_ADDR:    begin bus.bsel = 1'b1; bus.loadc = 1'b1; bus.load_addr = 1'b1; end
      S_MWR_GET: begin bus.nsel = 3'b100; bus.loadb = 1'b1; bus.asel = 1'b1; end
      S_MRD:     bus.mem_req = 1'b1;
      S_MWR:     begin bus.mem_req = 1'b1; bus.mem_we = 1'b1; end
      S_WMEM:    begin bus.nsel = 3'b100; bus.vsel = 2'b11; bus.write = 1'b1; end
      S_HALT:    bus.halted = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: each step queues the output vector the sequencer should show
// after the next clock edge, then pops and compares it on the falling edge.
module tb_datapath_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  datapath_sequencer_if bus ();

  datapath_sequencer #(.TIMEOUT(15), .CNT_W(4), .HALT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {w, loada,loadb,loadc,loads, write, nsel, vsel, asel,bsel,load_addr,mem_req,mem_we,halted,err}
  localparam logic [17:0] E_WAIT = {1'b1, 4'b0000, 1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_DEC  = {1'b0, 4'b0000, 1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_WIMM = {1'b0, 4'b0000, 1'b1, 3'b100, 2'b10, 7'b0000000};
  localparam logic [17:0] E_GETA = {1'b0, 4'b1000, 1'b0, 3'b001, 2'b00, 7'b0000000};
  localparam logic [17:0] E_GETB = {1'b0, 4'b0100, 1'b0, 3'b010, 2'b00, 7'b0000000};
  localparam logic [17:0] E_ALU  = {1'b0, 4'b0010, 1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_ALUZ = {1'b0, 4'b0010, 1'b0, 3'b000, 2'b00, 7'b1000000};
  localparam logic [17:0] E_COMP = {1'b0, 4'b0001, 1'b0, 3'b000, 2'b00, 7'b0000000};
  localparam logic [17:0] E_WREG = {1'b0, 4'b0000, 1'b1, 3'b100, 2'b00, 7'b0000000};
  localparam logic [17:0] E_ADDR = {1'b0, 4'b0010, 1'b0, 3'b000, 2'b00, 7'b0110000};
  localparam logic [17:0] E_MWRG = {1'b0, 4'b0100, 1'b0, 3'b100, 2'b00, 7'b1000000};
  localparam logic [17:0] E_MRD  = {1'b0, 4'b0000, 1'b0, 3'b000, 2'b00, 7'b0001000};
  localparam logic [17:0] E_MWR  = {1'b0, 4'b0000, 1'b0, 3'b000, 2'b00, 7'b0001100};
  localparam logic [17:0] E_WMEM = {1'b0, 4'b0000, 1'b1, 3'b100, 2'b11, 7'b0000000};
  localparam logic [17:0] E_HALT = {1'b0, 4'b0000, 1'b0, 3'b000, 2'b00, 7'b0000010};
  localparam logic [17:0] ERR    = 18'd1;

  logic [17:0] sb[$];

  function automatic logic [17:0] observed();
    return {bus.w, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write, bus.nsel,
            bus.vsel, bus.asel, bus.bsel, bus.load_addr, bus.mem_req, bus.mem_we,
            bus.halted, bus.err};
  endfunction

  task automatic check(input string tag);
    logic [17:0] e;
    logic [17:0] o;
    e = sb.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
    $display("t=%0t %-12s outputs=%b", $time, tag, o);
  endtask

  task automatic check_now(input logic [17:0] e, input string tag);
    sb.push_back(e);
    check(tag);
  endtask

  task automatic step(input logic [17:0] e, input string tag);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  task automatic start(input logic [2:0] opc, input logic [1:0] sub, input logic [17:0] err_bits);
    bus.s      = 1'b1;
    bus.opcode = opc;
    bus.op     = sub;
    step(E_DEC | err_bits, "decode");
    bus.s = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bus.s         = 1'b0;
    bus.opcode    = 3'b000;
    bus.op        = 2'b00;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    #1;
    check_now(E_WAIT, "reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(E_WAIT, "post_reset");

    // MOV immediate
    start(3'b110, 2'b10, 18'd0);
    step(E_WIMM, "mov_wimm");
    step(E_WAIT, "mov_done");

    // ADD
    start(3'b101, 2'b00, 18'd0);
    step(E_GETA, "add_geta");
    step(E_GETB, "add_getb");
    step(E_ALU,  "add_alu");
    step(E_WREG, "add_wreg");
    step(E_WAIT, "add_done");

    // CMP: loads, no write
    start(3'b101, 2'b01, 18'd0);
    step(E_GETA, "cmp_geta");
    step(E_GETB, "cmp_getb");
    step(E_COMP, "cmp_comp");
    step(E_WAIT, "cmp_done");

    // ALU op with A forced to zero: {101,11} and MOV-register {110,00}
    start(3'b101, 2'b11, 18'd0);
    step(E_GETA, "mvn_geta");
    step(E_GETB, "mvn_getb");
    step(E_ALUZ, "mvn_aluz");
    step(E_WREG, "mvn_wreg");
    step(E_WAIT, "mvn_done");
    start(3'b110, 2'b00, 18'd0);
    step(E_GETB, "movr_getb");
    step(E_ALUZ, "movr_aluz");
    step(E_WREG, "movr_wreg");
    step(E_WAIT, "movr_done");

    // mem_ready while idle is ignored
    bus.mem_ready = 1'b1;
    step(E_WAIT, "stray_ready");
    bus.mem_ready = 1'b0;

    // LDR, ready on the 3rd S_MRD cycle
    start(3'b011, 2'b00, 18'd0);
    step(E_GETA, "ldr_geta");
    step(E_ADDR, "ldr_addr");
    for (int i = 0; i < 3; i++) begin
      step(E_MRD, "ldr_mrd");
    end
    bus.mem_ready = 1'b1;
    step(E_WMEM, "ldr_wmem");
    bus.mem_ready = 1'b0;
    step(E_WAIT, "ldr_done");

    // LDR, ready on the final permitted cycle: completion wins, no error
    start(3'b011, 2'b00, 18'd0);
    step(E_GETA, "ldr2_geta");
    step(E_ADDR, "ldr2_addr");
    for (int i = 0; i < 15; i++) begin
      step(E_MRD, "ldr2_mrd");
    end
    bus.mem_ready = 1'b1;
    step(E_WMEM, "ldr2_wmem");
    bus.mem_ready = 1'b0;
    step(E_WAIT, "ldr2_done");

    // STR with no ready: 15 request cycles then abort with error
    start(3'b100, 2'b00, 18'd0);
    step(E_GETA, "str_geta");
    step(E_ADDR, "str_addr");
    step(E_MWRG, "str_mwrget");
    for (int i = 0; i < 15; i++) begin
      step(E_MWR, "str_mwr");
    end
    step(E_WAIT | ERR, "str_timeout");
    step(E_WAIT | ERR, "str_idle");

    // Reset clears error; illegal opcode sets it again
    rst_n = 1'b0;
    #1;
    check_now(E_WAIT, "rst_clear");
    @(negedge clk);
    rst_n = 1'b1;
    start(3'b000, 2'b00, 18'd0);
    step(E_WAIT | ERR, "illegal");

    // Reset in the middle of a memory read
    start(3'b011, 2'b00, ERR);
    step(E_GETA | ERR, "ldr3_geta");
    step(E_ADDR | ERR, "ldr3_addr");
    step(E_MRD | ERR,  "ldr3_mrd");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(E_WAIT, "rst_mid_mrd");
    @(negedge clk);
    rst_n = 1'b1;
    step(E_WAIT, "rst_release");

    // Illegal, then HALT holds for 20 cycles while s toggles
    start(3'b000, 2'b00, 18'd0);
    step(E_WAIT | ERR, "illegal2");
    start(3'b111, 2'b00, ERR);
    for (int i = 0; i < 20; i++) begin
      bus.s = i[0];
      step(E_HALT | ERR, "halt");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
